// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: widths and state/port enums for the L2 arbiter
package l2_arbiter_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 128;
  localparam int SEL_W = 16;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} l2arb_state_t;
  typedef enum logic {PORT_I, PORT_D} l2arb_port_t;
endpackage

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: one wishbone line-transfer channel (L1 miss port or L2 port)
interface l2_arbiter_if;
  import l2_arbiter_pkg::*;
  logic stb;
  logic cyc;
  logic we;
  logic [ADDR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DATA_W-1:0] dat_m;
  logic ack;
  logic [DATA_W-1:0] dat_s;
  modport master(output stb, cyc, we, adr, sel, dat_m, input ack, dat_s);
  modport slave(input stb, cyc, we, adr, sel, dat_m, output ack, dat_s);
endinterface

// File: rtl/l2_arbiter_req_latch.sv
// l2arb_req_latch: holds the granted request fields for the whole L2 access
module l2arb_req_latch
  import l2_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [SEL_W-1:0] sel,
  input  logic [DATA_W-1:0] dat_m,
  output logic q_we,
  output logic [ADDR_W-1:0] q_adr,
  output logic [SEL_W-1:0] q_sel,
  output logic [DATA_W-1:0] q_dat_m
);
  // capture the winner's fields on grant so L2 never sees live L1 inputs
  always_ff @(posedge clk or posedge rst)
    if (rst) {q_we, q_adr, q_sel, q_dat_m} <= '0;
    else if (load) {q_we, q_adr, q_sel, q_dat_m} <= {we, adr, sel, dat_m};
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the L2 wishbone slave between I and D L1 miss ports (round-robin ties with L2ARB_RR_EN)
module l2_arbiter
  import l2_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  l2_arbiter_if.slave i_wb,
  l2_arbiter_if.slave d_wb,
  l2_arbiter_if.master l2_wb
);
  l2arb_state_t state, state_n;
  l2arb_port_t win, cur;
  logic [DATA_W-1:0] ack_dat;
  logic i_req, d_req, load, busy;
  logic q_we;
  logic [ADDR_W-1:0] q_adr;
  logic [SEL_W-1:0] q_sel;
  logic [DATA_W-1:0] q_dat_m;
  assign i_req = i_wb.stb & i_wb.cyc;
  assign d_req = d_wb.stb & d_wb.cyc;
  assign load = (state == IDLE) & (i_req | d_req);
  assign busy = (state == BUSY_I) | (state == BUSY_D);
`ifdef L2ARB_RR_EN
  l2arb_port_t last_grant;
  assign win = (i_req & d_req) ? (last_grant == PORT_I ? PORT_D : PORT_I) : (d_req ? PORT_D : PORT_I);
  // remember who won so the next tie goes the other way
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= PORT_I;
    else if (load) last_grant <= win;
`else
  assign win = d_req ? PORT_D : PORT_I;
`endif
  l2arb_req_latch u_latch (
    .clk(clk),
    .rst(rst),
    .load(load),
    .we(win == PORT_D ? d_wb.we : i_wb.we),
    .adr(win == PORT_D ? d_wb.adr : i_wb.adr),
    .sel(win == PORT_D ? d_wb.sel : i_wb.sel),
    .dat_m(win == PORT_D ? d_wb.dat_m : i_wb.dat_m),
    .q_we(q_we),
    .q_adr(q_adr),
    .q_sel(q_sel),
    .q_dat_m(q_dat_m)
  );
  // state, granted port and the L2 read data captured at ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cur <= PORT_I;
      ack_dat <= '0;
    end else begin
      state <= state_n;
      if (load) cur <= win;
      if (busy & l2_wb.ack) ack_dat <= l2_wb.dat_s;
    end
  // next state and outputs; L1 requests are only looked at in IDLE
  always_comb begin
    state_n = state == IDLE ? (load ? (win == PORT_D ? BUSY_D : BUSY_I) : IDLE) :
              state == DONE ? IDLE : (l2_wb.ack ? DONE : state);
    l2_wb.stb = busy;
    l2_wb.cyc = busy;
    l2_wb.we = busy & q_we;
    l2_wb.adr = busy ? q_adr : '0;
    l2_wb.sel = busy ? q_sel : '0;
    l2_wb.dat_m = busy ? q_dat_m : '0;
    i_wb.ack = (state == DONE) & (cur == PORT_I);
    d_wb.ack = (state == DONE) & (cur == PORT_D);
    i_wb.dat_s = i_wb.ack ? ack_dat : '0;
    d_wb.dat_s = d_wb.ack ? ack_dat : '0;
  end
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed self-checking bench for l2_arbiter
module tb_l2_arbiter;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  localparam logic [127:0] DB = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
  localparam logic [127:0] DM = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  l2_arbiter_if i_wb();
  l2_arbiter_if d_wb();
  l2_arbiter_if l2_wb();
  l2_arbiter dut (.clk(clk), .rst(rst), .i_wb(i_wb), .d_wb(d_wb), .l2_wb(l2_wb));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic respond(input int n, input logic [127:0] v);
    repeat (n) tick();
    l2_wb.ack = 1;
    l2_wb.dat_s = v;
    tick();
    l2_wb.ack = 0;
    l2_wb.dat_s = '0;
  endtask
  task automatic test_reset();
    {i_wb.stb, i_wb.cyc, i_wb.we, i_wb.adr, i_wb.sel, i_wb.dat_m} = '0;
    {d_wb.stb, d_wb.cyc, d_wb.we, d_wb.adr, d_wb.sel, d_wb.dat_m} = '0;
    l2_wb.ack = 0;
    l2_wb.dat_s = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.cyc, l2_wb.we, l2_wb.adr, l2_wb.sel, l2_wb.dat_m, i_wb.ack, i_wb.dat_s, d_wb.ack, d_wb.dat_s} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stb=%b adr=%h i_ack=%b d_ack=%b, all required 0", l2_wb.stb, l2_wb.adr, i_wb.ack, d_wb.ack);
    end
  endtask
  task automatic test_i_read();
    i_wb.stb = 1; i_wb.cyc = 1; i_wb.we = 0; i_wb.adr = 12'h0a3; i_wb.sel = 16'hffff;
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.cyc, l2_wb.we, l2_wb.adr} !== {1'b1, 1'b1, 1'b0, 12'h0a3}) begin
      errors++;
      $display("FAIL i_read_req: stb=%b cyc=%b we=%b adr=%h, required 1 1 0 0a3", l2_wb.stb, l2_wb.cyc, l2_wb.we, l2_wb.adr);
    end
    tick();
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.adr, i_wb.ack} !== {1'b1, 12'h0a3, 1'b0}) begin
      errors++;
      $display("FAIL i_read_wait: stb=%b adr=%h i_ack=%b, required 1 0a3 0", l2_wb.stb, l2_wb.adr, i_wb.ack);
    end
    respond(0, DB);
    checks++;
    if ({i_wb.ack, i_wb.dat_s, d_wb.ack, d_wb.dat_s, l2_wb.stb} !== {1'b1, DB, 1'b0, 128'h0, 1'b0}) begin
      errors++;
      $display("FAIL i_read_ack: i_ack=%b i_dat=%h d_ack=%b stb=%b, required 1 %h 0 0", i_wb.ack, i_wb.dat_s, d_wb.ack, l2_wb.stb, DB);
    end
    i_wb.stb = 0; i_wb.cyc = 0;
    tick();
    checks++;
    if ({i_wb.ack, i_wb.dat_s, l2_wb.stb} !== {1'b0, 128'h0, 1'b0}) begin
      errors++;
      $display("FAIL i_read_after: i_ack=%b i_dat=%h stb=%b, required 0 0 0", i_wb.ack, i_wb.dat_s, l2_wb.stb);
    end
  endtask
  task automatic test_tie();
    logic first_d;
    logic [11:0] a2, a3;
    i_wb.stb = 1; i_wb.cyc = 1; i_wb.we = 0; i_wb.adr = 12'h010;
    d_wb.stb = 1; d_wb.cyc = 1; d_wb.we = 1; d_wb.adr = 12'h020; d_wb.sel = 16'h00ff; d_wb.dat_m = DM;
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.we, l2_wb.adr, l2_wb.sel, l2_wb.dat_m} !== {1'b1, 1'b1, 12'h020, 16'h00ff, DM}) begin
      errors++;
      $display("FAIL tie_d_first: stb=%b we=%b adr=%h sel=%h, required 1 1 020 00ff", l2_wb.stb, l2_wb.we, l2_wb.adr, l2_wb.sel);
    end
    respond(1, 128'h5);
    checks++;
    if ({d_wb.ack, d_wb.dat_s, i_wb.ack} !== {1'b1, 128'h5, 1'b0}) begin
      errors++;
      $display("FAIL tie_d_ack: d_ack=%b d_dat=%h i_ack=%b, required 1 5 0", d_wb.ack, d_wb.dat_s, i_wb.ack);
    end
    d_wb.we = 0; d_wb.adr = 12'h030;
    tick();
    tick();
`ifdef L2ARB_RR_EN
    first_d = 0; a2 = 12'h010; a3 = 12'h030;
`else
    first_d = 1; a2 = 12'h030; a3 = 12'h010;
`endif
    checks++;
    if ({l2_wb.stb, l2_wb.we, l2_wb.adr} !== {1'b1, 1'b0, a2}) begin
      errors++;
      $display("FAIL tie_second: stb=%b we=%b adr=%h, required 1 0 %h", l2_wb.stb, l2_wb.we, l2_wb.adr, a2);
    end
    respond(0, 128'h6);
    checks++;
    if ({d_wb.ack, i_wb.ack} !== {first_d, ~first_d}) begin
      errors++;
      $display("FAIL tie_second_ack: d_ack=%b i_ack=%b, required %b %b", d_wb.ack, i_wb.ack, first_d, ~first_d);
    end
    if (first_d) begin d_wb.stb = 0; d_wb.cyc = 0; end
    else begin i_wb.stb = 0; i_wb.cyc = 0; end
    tick();
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.adr} !== {1'b1, a3}) begin
      errors++;
      $display("FAIL tie_third: stb=%b adr=%h, required 1 %h", l2_wb.stb, l2_wb.adr, a3);
    end
    respond(0, 128'h7);
    checks++;
    if ({d_wb.ack, i_wb.ack} !== {~first_d, first_d}) begin
      errors++;
      $display("FAIL tie_third_ack: d_ack=%b i_ack=%b, required %b %b", d_wb.ack, i_wb.ack, ~first_d, first_d);
    end
    i_wb.stb = 0; i_wb.cyc = 0; d_wb.stb = 0; d_wb.cyc = 0;
    tick();
  endtask
  task automatic test_stable_fields();
    d_wb.stb = 1; d_wb.cyc = 1; d_wb.we = 1; d_wb.adr = 12'h111; d_wb.dat_m = DM;
    tick();
    d_wb.adr = 12'h222; d_wb.we = 0; d_wb.dat_m = '0;
    tick();
    checks++;
    if ({l2_wb.adr, l2_wb.we, l2_wb.dat_m} !== {12'h111, 1'b1, DM}) begin
      errors++;
      $display("FAIL stable_fields: adr=%h we=%b, required 111 1", l2_wb.adr, l2_wb.we);
    end
    tick();
    checks++;
    if (l2_wb.adr !== 12'h111) begin
      errors++;
      $display("FAIL stable_adr_late: adr=%h, required 111", l2_wb.adr);
    end
    respond(0, 128'h9);
    checks++;
    if ({d_wb.ack, d_wb.dat_s} !== {1'b1, 128'h9}) begin
      errors++;
      $display("FAIL stable_ack: d_ack=%b d_dat=%h, required 1 9", d_wb.ack, d_wb.dat_s);
    end
    d_wb.stb = 0; d_wb.cyc = 0;
    tick();
  endtask
  task automatic test_no_abort();
    i_wb.stb = 1; i_wb.cyc = 1; i_wb.we = 0; i_wb.adr = 12'h0c4;
    tick();
    i_wb.stb = 0; i_wb.cyc = 0;
    respond(1, 128'hab);
    checks++;
    if ({i_wb.ack, i_wb.dat_s} !== {1'b1, 128'hab}) begin
      errors++;
      $display("FAIL no_abort_ack: i_ack=%b i_dat=%h, required 1 ab", i_wb.ack, i_wb.dat_s);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    i_wb.stb = 1; i_wb.cyc = 1; i_wb.we = 0; i_wb.adr = 12'h0aa;
    tick();
    rst = 1;
    #1;
    checks++;
    if ({l2_wb.stb, l2_wb.cyc, l2_wb.adr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: stb=%b adr=%h, required 0 000", l2_wb.stb, l2_wb.adr);
    end
    i_wb.stb = 0; i_wb.cyc = 0;
    tick();
    rst = 0;
    respond(0, 128'hff);
    checks++;
    if ({i_wb.ack, d_wb.ack, l2_wb.stb, l2_wb.we, l2_wb.adr, l2_wb.sel, l2_wb.dat_m} !== '0) begin
      errors++;
      $display("FAIL reset_mid_ack: i_ack=%b d_ack=%b stb=%b adr=%h, required all 0", i_wb.ack, d_wb.ack, l2_wb.stb, l2_wb.adr);
    end
    d_wb.stb = 1; d_wb.cyc = 1; d_wb.we = 0; d_wb.adr = 12'h055;
    tick();
    checks++;
    if ({l2_wb.stb, l2_wb.adr} !== {1'b1, 12'h055}) begin
      errors++;
      $display("FAIL reset_mid_regrant: stb=%b adr=%h, required 1 055", l2_wb.stb, l2_wb.adr);
    end
    respond(0, 128'h3);
    checks++;
    if ({d_wb.ack, d_wb.dat_s} !== {1'b1, 128'h3}) begin
      errors++;
      $display("FAIL reset_mid_regrant_ack: d_ack=%b d_dat=%h, required 1 3", d_wb.ack, d_wb.dat_s);
    end
    d_wb.stb = 0; d_wb.cyc = 0;
    tick();
  endtask
  task automatic test_spurious_ack();
    respond(0, 128'h77);
    checks++;
    if ({i_wb.ack, d_wb.ack, i_wb.dat_s, d_wb.dat_s, l2_wb.stb} !== '0) begin
      errors++;
      $display("FAIL spurious_ack: i_ack=%b d_ack=%b stb=%b, required 0 0 0", i_wb.ack, d_wb.ack, l2_wb.stb);
    end
    tick();
    checks++;
    if ({i_wb.ack, d_wb.ack, l2_wb.stb} !== '0) begin
      errors++;
      $display("FAIL spurious_ack_later: i_ack=%b d_ack=%b stb=%b, required 0 0 0", i_wb.ack, d_wb.ack, l2_wb.stb);
    end
  endtask
  task automatic test_hold_through_done();
    d_wb.stb = 1; d_wb.cyc = 1; d_wb.we = 1; d_wb.adr = 12'h066;
    tick();
    respond(0, 128'h44);
    checks++;
    if ({d_wb.ack, d_wb.dat_s} !== {1'b1, 128'h44}) begin
      errors++;
      $display("FAIL hold_ack: d_ack=%b d_dat=%h, required 1 44", d_wb.ack, d_wb.dat_s);
    end
    tick();
    checks++;
    if ({l2_wb.stb, d_wb.ack} !== 2'b00) begin
      errors++;
      $display("FAIL hold_no_regrant: stb=%b d_ack=%b, required 0 0", l2_wb.stb, d_wb.ack);
    end
    d_wb.stb = 0; d_wb.cyc = 0;
    tick();
    checks++;
    if (l2_wb.stb !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: stb=%b, required 0", l2_wb.stb);
    end
  endtask
  initial begin
    test_reset();
    test_i_read();
    test_tie();
    test_stable_fields();
    test_no_abort();
    test_reset_mid();
    test_spurious_ack();
    test_hold_through_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
